sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Clocked responder model of the external 16-bit asynchronous SRAM. It sits on the far end of the SRAM pins that the memory-stage SRAM controller drives.
- It stores data, honours the byte lanes, returns read data after a programmable latency, and counts accesses.
- It flags protocol misuse so the controller can be verified standalone and in full-pipeline simulation.

Parameters:
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, SRAM data width. Two byte lanes; fixed at 16.
- READ_LAT, 2, clk cycles from an accepted read to data driven on SRAM_DQ. Legal range 1..15.
- MEM_DEPTH, 2**ADDR_W, number of implemented words. Address bits above log2(MEM_DEPTH) are ignored.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- SRAM_adr  in  ADDR_W  word address from the controller.
- SRAM_DQ  inout  DATA_W  bidirectional data bus.
- SRAM_UB_N  in  1  upper byte lane enable [15:8], active low.
- SRAM_LB_N  in  1  lower byte lane enable [7:0], active low.
- SRAM_WE_N  in  1  write enable, active low.
- SRAM_CE_N  in  1  chip enable, active low.
- SRAM_OE_N  in  1  output enable, active low.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky protocol-violation flag.
- wr_count  out  16  accepted writes; wraps modulo 2^16.
- rd_count  out  16  completed reads; wraps modulo 2^16.

Behaviour:
- Reset values: state=IDLE, busy=0, err=0, wr_count=0, rd_count=0, rd_adr=0, lat_cnt=0, SRAM_DQ all-Z.
- Reset takes effect immediately, including mid-read: DQ is released in the same delta. The memory array is NOT reset and keeps its contents.
- Decoded strobes, sampled at the clk edge:
  - wr = !CE_N & !WE_N
  - rd = !CE_N & WE_N & !OE_N
- Write, accepted in any state:
  - Lanes with UB_N/LB_N low are written with SRAM_DQ at that edge.
  - wr_count increments only if at least one lane is enabled. A write with both lanes disabled is a no-op.
  - The next state is IDLE, which aborts any read in progress. Write has priority over read.
- State machine, with lat_cnt 4 bits:
  - IDLE: on rd, latch rd_adr=SRAM_adr. If READ_LAT==1 go to RD_DRIVE; otherwise lat_cnt=READ_LAT-1 and go to RD_WAIT.
  - RD_WAIT:
    - If rd is low, go to IDLE.
    - Else if SRAM_adr!=rd_adr, re-latch rd_adr, reload lat_cnt=READ_LAT-1 and stay (latency restarts).
    - Else if lat_cnt==1, go to RD_DRIVE.
    - Else decrement lat_cnt.
  - RD_DRIVE:
    - rd_count increments on the entry edge.
    - Stay while rd is high and SRAM_adr==rd_adr.
    - On an address change with rd high, behave as IDLE accepting a new read: re-latch, then go to RD_WAIT, or to RD_DRIVE when READ_LAT==1 (which counts a new read).
    - If rd is low, go to IDLE.
- DQ drive, combinational:
  - SRAM_DQ[15:8] = mem[rd_adr][15:8] when state==RD_DRIVE & rd & !UB_N; else Z.
  - SRAM_DQ[7:0] follows the same rule with LB_N.
  - DQ is never driven while WE_N is low.
- Timing: data is visible exactly READ_LAT rising edges after the edge that accepted the read.
- err is set, and held until rst, on any edge where:
  - CE_N, WE_N and OE_N are all low (bus contention), or
  - SRAM_adr or a lane enable contains X/Z while CE_N is low (simulation-only check, ignored in synthesis).
- Write data in the same cycle as a read of the same address: the read returns the new data, because the write aborts the read.

Decomposition:
- Package sram_pkg holds:
  - state encoding (IDLE=2'd0, RD_WAIT=2'd1, RD_DRIVE=2'd2);
  - default ADDR_W, DATA_W and READ_LAT constants;
  - lane index constants (UB=1, LB=0).
- Sub-module sram_byte_array: MEM_DEPTH x 16 storage with a 2-bit byte-enable synchronous write port and an asynchronous read port. The top level holds the FSM, latency counter, access counters, DQ tri-state and error checks.

Test Plan:
- Write 16'h1234 to adr 5, both lanes, then hold a read of adr 5 with READ_LAT=2 -> DQ is Z for 1 cycle, 16'h1234 appears after the 2nd edge; wr_count=1, rd_count=1.
- UB-only write 16'hAB00 to adr 5, then read both lanes -> 16'hAB34. A read with LB_N=1 -> DQ[7:0]=Z, DQ[15:8]=8'hAB.
- Change adr from 5 to 6 one cycle into RD_WAIT -> latency restarts; adr 6 data appears 2 edges after the change. rd_count increments by 1 only.
- Drive CE_N=0, WE_N=0, OE_N=0 for one cycle -> err=1 and stays 1; the write is performed; DQ is not driven.
- Assert rst while in RD_DRIVE -> DQ goes Z immediately; busy=0, counters=0, err=0. A subsequent read of adr 5 still returns 16'hAB34.
- Perform 65537 single-lane writes -> wr_count wraps to 1. A both-lanes-disabled write leaves wr_count unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM encoding, default geometry/latency and byte-lane indices for the SRAM responder
package sram_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } state_t;
  localparam int DEF_ADDR_W   = 18;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_READ_LAT = 2;
  localparam int UB = 1;
  localparam int LB = 0;
endpackage

// File: rtl/sram_byte_array.sv
// sram_byte_array: DEPTH x 16 storage, byte-enabled synchronous write (we, be, wadr, wdata), async read (radr -> rdata); contents are never reset
module sram_byte_array #(
  parameter int AW    = 18,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] wadr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] radr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (we && be[i]) mem[wadr][i*8 +: 8] <= wdata[i*8 +: 8];
  assign rdata = mem[radr];
endmodule

// File: rtl/sram_responder.sv
// sram_responder: clocked model of a 16-bit async SRAM with programmable read latency, access counters and a sticky protocol-error flag
//   clk/rst      : clock, async active-high reset (memory contents survive reset)
//   SRAM_*       : controller-side SRAM pins; SRAM_DQ is driven only during RD_DRIVE on enabled lanes
//   busy         : state is not IDLE
//   err          : sticky CE/WE/OE contention or unknown address/lane while selected
//   wr_count     : accepted writes with at least one lane enabled, wraps
//   rd_count     : completed reads (entries into RD_DRIVE), wraps
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter int MEM_DEPTH = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_adr,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic              busy,
  output logic              err,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);
  state_t state;
  logic [ADDR_W-1:0] rd_adr;
  logic [3:0] lat_cnt;
  logic [15:0] rdata;
  logic [1:0] lane_en;
  logic wr, rd, new_rd, drive, contention, xz_bad;
  assign wr = !SRAM_CE_N && !SRAM_WE_N;
  assign rd = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign lane_en = {!SRAM_UB_N, !SRAM_LB_N};
  assign contention = !SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N;
  // a read is (re)started from IDLE or whenever the address moves away from the latched one
  assign new_rd = rd && (state == IDLE || SRAM_adr != rd_adr);
  assign drive = state == RD_DRIVE && rd;
  assign SRAM_DQ[15:8] = drive && lane_en[UB] ? rdata[15:8] : 8'bz;
  assign SRAM_DQ[7:0]  = drive && lane_en[LB] ? rdata[7:0]  : 8'bz;
`ifndef SYNTHESIS
  assign xz_bad = !SRAM_CE_N && $isunknown({SRAM_adr, SRAM_UB_N, SRAM_LB_N});
`else
  assign xz_bad = 1'b0;
`endif
  sram_byte_array #(.AW(AW), .DEPTH(MEM_DEPTH)) u_array (
    .clk   (clk),
    .we    (wr),
    .be    (lane_en),
    .wadr  (SRAM_adr[AW-1:0]),
    .wdata (SRAM_DQ),
    .radr  (rd_adr[AW-1:0]),
    .rdata (rdata)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      err      <= 1'b0;
      rd_adr   <= '0;
      lat_cnt  <= '0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (contention || xz_bad) err <= 1'b1;
      if (wr) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (|lane_en) wr_count <= wr_count + 16'd1;
      end else if (!rd) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (new_rd) begin
        rd_adr <= SRAM_adr;
        busy   <= 1'b1;
        if (READ_LAT == 1) begin
          state    <= RD_DRIVE;
          rd_count <= rd_count + 16'd1;
        end else begin
          state   <= RD_WAIT;
          lat_cnt <= LAT_M1;
        end
      end else if (state == RD_WAIT) begin
        if (lat_cnt == 4'd1) begin
          state    <= RD_DRIVE;
          rd_count <= rd_count + 16'd1;
        end else lat_cnt <= lat_cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench for sram_responder; undriven DQ reads as all-ones via pullups
module tb_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [17:0] sram_adr = '0;
  logic ub_n = 1'b0, lb_n = 1'b0, we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1;
  logic [15:0] dq_drv = '0;
  logic dq_en = 1'b0;
  wire  [15:0] dq;
  logic busy, err;
  logic [15:0] wr_count, rd_count;
  logic [15:0] model [int];
  logic [15:0] exp_q [$];
  logic [15:0] exp_v;
  int checks = 0;
  int errors = 0;

  assign dq = dq_en ? dq_drv : 16'bz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
  end

  always #5 clk = ~clk;

  sram_responder dut (
    .clk       (clk),
    .rst       (rst),
    .SRAM_adr  (sram_adr),
    .SRAM_DQ   (dq),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_WE_N (we_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .busy      (busy),
    .err       (err),
    .wr_count  (wr_count),
    .rd_count  (rd_count)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_read(input int a, input logic ub, input logic lb);
    logic [15:0] m;
    m = model[a];
    return {ub ? 8'hFF : m[15:8], lb ? 8'hFF : m[7:0]};
  endfunction

  task automatic do_write(input int a, input logic [15:0] d, input logic ub, input logic lb);
    sram_adr = 18'(a);
    dq_drv = d;
    dq_en = 1'b1;
    ub_n = ub;
    lb_n = lb;
    ce_n = 1'b0;
    we_n = 1'b0;
    oe_n = 1'b1;
    if (!model.exists(a)) model[a] = 16'h0000;
    if (!ub) model[a][15:8] = d[15:8];
    if (!lb) model[a][7:0] = d[7:0];
    tick();
    ce_n = 1'b1;
    we_n = 1'b1;
    dq_en = 1'b0;
    ub_n = 1'b0;
    lb_n = 1'b0;
  endtask

  task automatic start_read(input int a, input logic ub, input logic lb);
    sram_adr = 18'(a);
    ub_n = ub;
    lb_n = lb;
    ce_n = 1'b0;
    we_n = 1'b1;
    oe_n = 1'b0;
  endtask

  task automatic end_read();
    ce_n = 1'b1;
    oe_n = 1'b1;
    ub_n = 1'b0;
    lb_n = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
    checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL reset_dq: got %h expected ffff", dq); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    do_write(5, 16'h1234, 1'b0, 1'b0);
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wr_count_1: got %0d expected 1", wr_count); end
    start_read(5, 1'b0, 1'b0);
    exp_q.push_back(exp_read(5, 1'b0, 1'b0));
    tick();
    checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL lat_wait_dq: got %h expected ffff", dq); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_wait_busy: got %b expected 1", busy); end
    tick();
    if (exp_q.size() == 0) begin errors++; $display("FAIL rd5_sb: scoreboard empty"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (dq !== exp_v) begin errors++; $display("FAIL rd5_data: got %h expected %h", dq, exp_v); end
    end
    checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL rd_count_1: got %0d expected 1", rd_count); end
    end_read();
    checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL release_dq: got %h expected ffff", dq); end
  endtask

  task automatic test_byte_lanes();
    do_write(5, 16'hAB00, 1'b0, 1'b1);
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL wr_count_2: got %0d expected 2", wr_count); end
    start_read(5, 1'b0, 1'b0);
    exp_q.push_back(exp_read(5, 1'b0, 1'b0));
    tick();
    tick();
    if (exp_q.size() == 0) begin errors++; $display("FAIL ub_merge_sb: scoreboard empty"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (dq !== exp_v) begin errors++; $display("FAIL ub_merge_data: got %h expected %h", dq, exp_v); end
    end
    lb_n = 1'b1;
    exp_q.push_back(exp_read(5, 1'b0, 1'b1));
    #1;
    if (exp_q.size() == 0) begin errors++; $display("FAIL lb_off_sb: scoreboard empty"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (dq !== exp_v) begin errors++; $display("FAIL lb_off_data: got %h expected %h", dq, exp_v); end
    end
    checks++; if (rd_count !== 16'd2) begin errors++; $display("FAIL rd_count_2: got %0d expected 2", rd_count); end
    end_read();
  endtask

  task automatic test_adr_change();
    do_write(6, 16'h5678, 1'b0, 1'b0);
    start_read(5, 1'b0, 1'b0);
    tick();
    sram_adr = 18'd6;
    exp_q.push_back(exp_read(6, 1'b0, 1'b0));
    tick();
    checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL restart_dq: got %h expected ffff", dq); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", busy); end
    tick();
    if (exp_q.size() == 0) begin errors++; $display("FAIL restart_sb: scoreboard empty"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (dq !== exp_v) begin errors++; $display("FAIL restart_data: got %h expected %h", dq, exp_v); end
    end
    checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL rd_count_3: got %0d expected 3", rd_count); end
    end_read();
  endtask

  task automatic test_contention();
    sram_adr = 18'd7;
    dq_drv = 16'h0F0F;
    dq_en = 1'b1;
    ub_n = 1'b0;
    lb_n = 1'b0;
    ce_n = 1'b0;
    we_n = 1'b0;
    oe_n = 1'b0;
    model[7] = 16'h0F0F;
    #1;
    checks++; if (dq !== 16'h0F0F) begin errors++; $display("FAIL contention_dq: got %h expected 0f0f", dq); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL contention_err: got %b expected 1", err); end
    checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL contention_wr_count: got %0d expected 4", wr_count); end
    ce_n = 1'b1;
    we_n = 1'b1;
    oe_n = 1'b1;
    dq_en = 1'b0;
    tick();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    start_read(7, 1'b0, 1'b0);
    exp_q.push_back(exp_read(7, 1'b0, 1'b0));
    tick();
    tick();
    if (exp_q.size() == 0) begin errors++; $display("FAIL contention_rd_sb: scoreboard empty"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (dq !== exp_v) begin errors++; $display("FAIL contention_rd_data: got %h expected %h", dq, exp_v); end
    end
    end_read();
  endtask

  task automatic test_reset_mid_read();
    start_read(5, 1'b0, 1'b0);
    exp_q.push_back(exp_read(5, 1'b0, 1'b0));
    tick();
    tick();
    if (exp_q.size() == 0) begin errors++; $display("FAIL pre_rst_sb: scoreboard empty"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (dq !== exp_v) begin errors++; $display("FAIL pre_rst_data: got %h expected %h", dq, exp_v); end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL mid_rst_dq: got %h expected ffff", dq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b expected 0", err); end
    checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin errors++; $display("FAIL mid_rst_counts: got wr=%0d rd=%0d expected 0 0", wr_count, rd_count); end
    tick();
    ce_n = 1'b1;
    oe_n = 1'b1;
    rst = 1'b0;
    tick();
    start_read(5, 1'b0, 1'b0);
    exp_q.push_back(exp_read(5, 1'b0, 1'b0));
    tick();
    tick();
    if (exp_q.size() == 0) begin errors++; $display("FAIL post_rst_sb: scoreboard empty"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (dq !== exp_v) begin errors++; $display("FAIL post_rst_data: got %h expected %h", dq, exp_v); end
    end
    checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL post_rst_rd_count: got %0d expected 1", rd_count); end
    end_read();
  endtask

  task automatic test_wrap();
    logic [7:0] last_lo;
    last_lo = '0;
    sram_adr = 18'd100;
    ub_n = 1'b1;
    lb_n = 1'b0;
    ce_n = 1'b0;
    we_n = 1'b0;
    oe_n = 1'b1;
    dq_en = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      last_lo = 8'(i ^ 32'h5A);
      dq_drv = {8'hC3, last_lo};
      tick();
    end
    model[100] = {8'h00, last_lo};
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wrap_wr_count: got %0d expected 1", wr_count); end
    lb_n = 1'b1;
    dq_drv = 16'h5555;
    tick();
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL noop_wr_count: got %0d expected 1", wr_count); end
    ce_n = 1'b1;
    we_n = 1'b1;
    dq_en = 1'b0;
    tick();
    start_read(100, 1'b1, 1'b0);
    exp_q.push_back(exp_read(100, 1'b1, 1'b0));
    tick();
    tick();
    if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_rd_sb: scoreboard empty"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (dq !== exp_v) begin errors++; $display("FAIL wrap_rd_data: got %h expected %h", dq, exp_v); end
    end
    end_read();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_adr_change();
    test_contention();
    test_reset_mid_read();
    test_wrap();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
